// File: rtl/vr_store_unit_if.sv
// Store request and data-memory write bundle for vr_store_unit.
// slave is the unit side; master is the execute/memory side.
interface vr_store_unit_if;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic [2:0]  i_funct3;
  logic        o_mem_wen;
  logic        i_mem_ready;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_wmask;
  logic        o_done;
  logic        o_err;

  modport slave (
    input  i_valid, i_addr, i_data, i_funct3, i_mem_ready,
    output o_ready, o_mem_wen, o_mem_addr, o_mem_wdata,
    output o_mem_wmask, o_done, o_err
  );

  modport master (
    output i_valid, i_addr, i_data, i_funct3, i_mem_ready,
    input  o_ready, o_mem_wen, o_mem_addr, o_mem_wdata,
    input  o_mem_wmask, o_done, o_err
  );
endinterface

// File: rtl/vr_store_unit.sv
// Store path: byte/half/word stores to word-aligned masked writes,
// splitting stores that straddle a word boundary into two writes.
module vr_store_unit (
  input logic        i_clk,
  input logic        i_rstn,
  vr_store_unit_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, WR0, WR1, DONE, ERR
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [63:0] shift_q, shift_d;
  logic [7:0]  mask_q, mask_d;

  logic        ready_q, ready_d;
  logic        wen_q, wen_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;

  logic [3:0]  size_mask;
  logic        legal;
  logic        accept;
  logic        hs;

  assign accept = bus.i_valid & ready_q;
  assign hs     = wen_q & bus.i_mem_ready;

  always_comb begin
    legal     = 1'b1;
    size_mask = 4'b0000;
    unique case (bus.i_funct3)
      3'h0:    size_mask = 4'b0001;
      3'h1:    size_mask = 4'b0011;
      3'h2:    size_mask = 4'b1111;
      default: legal     = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    shift_d = shift_q;
    mask_d  = mask_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          base_d  = {bus.i_addr[31:2], 2'b00};
          shift_d = {32'b0, bus.i_data}
                    << {bus.i_addr[1:0], 3'b000};
          mask_d  = {4'b0, size_mask} << bus.i_addr[1:0];
          state_d = legal ? WR0 : ERR;
        end
      end
      WR0: begin
        if (hs)
          state_d = (|mask_q[7:4]) ? WR1 : DONE;
      end
      WR1: begin
        if (hs)
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered decodes of the next state and fields.
  always_comb begin
    ready_d = (state_d == IDLE);
    wen_d   = (state_d == WR0) || (state_d == WR1);
    done_d  = (state_d == DONE) || (state_d == ERR);
    err_d   = (state_d == ERR);
    addr_d  = 32'b0;
    wdata_d = 32'b0;
    wmask_d = 4'b0;
    if (state_d == WR0) begin
      addr_d  = base_d;
      wdata_d = shift_d[31:0];
      wmask_d = mask_d[3:0];
    end else if (state_d == WR1) begin
      addr_d  = base_d + 32'd4;
      wdata_d = shift_d[63:32];
      wmask_d = mask_d[7:4];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      base_q  <= '0;
      shift_q <= '0;
      mask_q  <= '0;
      ready_q <= 1'b0;
      wen_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      shift_q <= shift_d;
      mask_q  <= mask_d;
      ready_q <= ready_d;
      wen_q   <= wen_d;
      done_q  <= done_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  assign bus.o_ready     = ready_q;
  assign bus.o_mem_wen   = wen_q;
  assign bus.o_done      = done_q;
  assign bus.o_err       = err_q;
  assign bus.o_mem_addr  = addr_q;
  assign bus.o_mem_wdata = wdata_q;
  assign bus.o_mem_wmask = wmask_q;
endmodule

// File: tb/tb_vr_store_unit.sv
// Bench for vr_store_unit: directed cases plus random stores
// checked against a byte-level store model.
module tb_vr_store_unit;
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  vr_store_unit_if bus ();

  vr_store_unit dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

  task automatic wait_ready();
    int w;
    w = 0;
    while (!bus.o_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("ready_before_accept", 64'(bus.o_ready), 64'd1);
  endtask

  task automatic run_store(input logic [31:0] a,
                           input logic [31:0] d,
                           input logic [2:0]  f3,
                           input int          forced,
                           input bit          rnd);
    logic [31:0] ea[2], ed[2], ga[2], gd[2];
    logic [3:0]  em[2], gm[2];
    logic [31:0] ba, w, paddr, pdata;
    logic [3:0]  pmask;
    int n, size, lane, c, got, stalls, done_c, left;
    bit prev_hold, err_seen, rdy;

    size = (f3 == 3'h0) ? 1 : (f3 == 3'h1) ? 2 :
           (f3 == 3'h2) ? 4 : 0;
    n = 0;
    for (int k = 0; k < size; k++) begin
      ba = a + 32'(k);
      w  = {ba[31:2], 2'b00};
      if (n == 0 || ea[n-1] != w) begin
        ea[n] = w; em[n] = 4'b0; ed[n] = 32'b0;
        n++;
      end
      lane = int'(ba[1:0]);
      em[n-1][lane] = 1'b1;
      ed[n-1][lane*8 +: 8] = d[k*8 +: 8];
    end

    wait_ready();
    bus.i_valid  = 1'b1;
    bus.i_addr   = a;
    bus.i_data   = d;
    bus.i_funct3 = f3;
    bus.i_mem_ready = 1'($urandom % 2);
    @(negedge clk);
    bus.i_valid  = 1'b0;
    bus.i_addr   = $urandom;
    bus.i_data   = $urandom;
    bus.i_funct3 = 3'($urandom);

    c = 1; got = 0; stalls = 0; done_c = -1;
    prev_hold = 1'b0; err_seen = 1'b0; left = forced;
    paddr = '0; pdata = '0; pmask = '0;
    while (c < 40) begin
      if (prev_hold) begin
        check("hold_wen",  64'(bus.o_mem_wen), 64'd1);
        check("hold_addr", 64'(bus.o_mem_addr), 64'(paddr));
        check("hold_data", 64'(bus.o_mem_wdata), 64'(pdata));
        check("hold_mask", 64'(bus.o_mem_wmask), 64'(pmask));
      end
      if (bus.o_mem_wen) begin
        if (left > 0) begin
          rdy = 1'b0;
          left--;
        end else if (rnd) begin
          rdy = ($urandom % 3) != 0;
        end else begin
          rdy = 1'b1;
        end
        bus.i_mem_ready = rdy;
        if (rdy) begin
          if (got < 2) begin
            ga[got] = bus.o_mem_addr;
            gd[got] = bus.o_mem_wdata;
            gm[got] = bus.o_mem_wmask;
          end
          got++;
          prev_hold = 1'b0;
        end else begin
          stalls++;
          prev_hold = 1'b1;
          paddr = bus.o_mem_addr;
          pdata = bus.o_mem_wdata;
          pmask = bus.o_mem_wmask;
        end
      end else begin
        bus.i_mem_ready = 1'($urandom % 2);
        prev_hold = 1'b0;
      end
      if (bus.o_done) begin
        done_c = c;
        err_seen = bus.o_err;
        break;
      end
      @(negedge clk);
      c++;
    end

    check("n_writes", 64'(got), 64'(n));
    for (int i = 0; i < n && i < got && i < 2; i++) begin
      check("wr_addr", 64'(ga[i]), 64'(ea[i]));
      check("wr_mask", 64'(gm[i]), 64'(em[i]));
      check("wr_data", 64'(gd[i] & lanes(em[i])),
            64'(ed[i]));
    end
    check("done_cycle", 64'(done_c),
          64'((n == 0) ? 1 : 1 + n + stalls));
    check("err", 64'(err_seen), 64'(size == 0));
    @(negedge clk);
    check("ready_after", 64'(bus.o_ready), 64'd1);
    check("done_pulse", 64'(bus.o_done), 64'd0);
  endtask

  task automatic reset_mid_wr1();
    bit seen;
    wait_ready();
    bus.i_valid  = 1'b1;
    bus.i_addr   = 32'h0000_0003;
    bus.i_data   = 32'h0000_5a6b;
    bus.i_funct3 = 3'h1;
    bus.i_mem_ready = 1'b0;
    @(negedge clk);
    bus.i_valid = 1'b0;
    check("rst_wr0_mask", 64'(bus.o_mem_wmask), 64'h8);
    bus.i_mem_ready = 1'b1;
    @(negedge clk);
    check("rst_wr1_addr", 64'(bus.o_mem_addr), 64'h4);
    bus.i_mem_ready = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    check("rst_wen",   64'(bus.o_mem_wen), 64'd0);
    check("rst_ready", 64'(bus.o_ready), 64'd0);
    rstn = 1'b1;
    bus.i_mem_ready = 1'b1;
    @(negedge clk);
    check("rst_release_ready", 64'(bus.o_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.o_mem_wen || bus.o_done) seen = 1'b1;
      @(negedge clk);
    end
    check("rst_no_activity", 64'(seen), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] f3;
    int r;
    bus.i_valid = 1'b0;
    bus.i_addr = '0;
    bus.i_data = '0;
    bus.i_funct3 = '0;
    bus.i_mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ready", 64'(bus.o_ready), 64'd0);
    check("reset_wen",   64'(bus.o_mem_wen), 64'd0);
    check("reset_done",  64'(bus.o_done), 64'd0);
    check("reset_err",   64'(bus.o_err), 64'd0);
    check("reset_addr",  64'(bus.o_mem_addr), 64'd0);
    check("reset_wdata", 64'(bus.o_mem_wdata), 64'd0);
    check("reset_wmask", 64'(bus.o_mem_wmask), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("first_ready", 64'(bus.o_ready), 64'd1);

    run_store(32'h0000_0100, 32'hdead_beef, 3'h2, 0, 1'b0);
    run_store(32'h0000_0103, 32'h0000_00ab, 3'h0, 0, 1'b0);
    run_store(32'h0000_0203, 32'h0000_1234, 3'h1, 0, 1'b0);
    run_store(32'hffff_fffe, 32'h1122_3344, 3'h2, 0, 1'b0);
    run_store(32'h0000_0040, 32'h1234_5678, 3'h3, 0, 1'b0);
    run_store(32'h0000_0010, 32'hcafe_f00d, 3'h2, 3, 1'b0);
    reset_mid_wr1();

    for (int i = 0; i < 80; i++) begin
      r  = int'($urandom % 8);
      f3 = (r < 6) ? 3'(r % 3) : 3'(3 + $urandom % 5);
      run_store($urandom, $urandom, f3, 0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
